// File: rtl/operand_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// operand_fetch_arbiter
//
// Two requesters share one two-port register file. Each accepted request
// fetches two operands (a and b), and the pair is returned as one response.
// Only one fetch is in flight at a time. Round-robin arbitration decides
// which requester wins when both ask in the same cycle.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   reqN_valid          : fetch request from requester N (N = 0, 1)
//   reqN_addr_a/_b      : operand addresses from requester N
//   reqN_ready          : requester N's request is accepted this cycle
//   rf_addr_a/_b        : registered addresses sent to the register file
//   rf_a, rf_b          : combinational read data from the register file
//   rsp_valid, rsp_id   : response available, and the requester that owns it
//   rsp_a, rsp_b        : fetched operands
//   rsp_ready           : the consumer takes the response
//   busy                : a fetch is in flight (state is not IDLE)
// ---------------------------------------------------------------------------
module operand_fetch_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr_a,
  input  logic [ADDR_W-1:0] req0_addr_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr_a,
  input  logic [ADDR_W-1:0] req1_addr_b,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] rf_addr_a_q, rf_addr_a_d;
  logic [ADDR_W-1:0] rf_addr_b_q, rf_addr_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
  logic [DATA_W-1:0] rsp_b_q, rsp_b_d;

  logic idle_ok;
  logic grant0;
  logic grant1;

  // Grants are only offered in IDLE and never while reset is high. When both
  // requesters ask at once, the one that did not win last time gets the grant.
  always_comb begin
    idle_ok = (state_q == ST_IDLE) && !reset;
    grant0  = idle_ok && req0_valid && (!req1_valid || last_grant_q);
    grant1  = idle_ok && req1_valid && (!req0_valid || !last_grant_q);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rf_addr_a_d  = rf_addr_a_q;
    rf_addr_b_d  = rf_addr_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_a_d      = rsp_a_q;
    rsp_b_d      = rsp_b_q;
    case (state_q)
      ST_IDLE: begin
        // Accept: latch the winner's addresses; the requester may change
        // them from the next cycle on without affecting this fetch.
        if (grant0 || grant1) begin
          state_d      = ST_FETCH;
          last_grant_d = grant1;
          rsp_id_d     = grant1;
          rf_addr_a_d  = grant1 ? req1_addr_a : req0_addr_a;
          rf_addr_b_d  = grant1 ? req1_addr_b : req0_addr_b;
        end
      end
      ST_FETCH: begin
        // Register-file data is valid for the registered addresses now.
        rsp_a_d     = rf_a;
        rsp_b_d     = rf_b;
        rsp_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rf_addr_a_q  <= '0;
      rf_addr_b_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_a_q      <= '0;
      rsp_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rf_addr_a_q  <= rf_addr_a_d;
      rf_addr_b_q  <= rf_addr_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_a_q      <= rsp_a_d;
      rsp_b_q      <= rsp_b_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rf_addr_a  = rf_addr_a_q;
  assign rf_addr_b  = rf_addr_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_a      = rsp_a_q;
  assign rsp_b      = rsp_b_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_operand_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch_arbiter
//
// Drives directed scenarios and then random traffic into
// operand_fetch_arbiter. A transaction-level reference model (pending fetch,
// cycles since accept, captured response) predicts every output in every
// cycle. A small array stands in for the register file.
// ---------------------------------------------------------------------------
module tb_operand_fetch_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr_a, req0_addr_b, req1_addr_a, req1_addr_b;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] rf_addr_a, rf_addr_b;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic              rsp_valid, rsp_id, rsp_ready, busy;
  logic [DATA_W-1:0] rsp_a, rsp_b;

  logic [DATA_W-1:0] mem [16];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic              m_pend;
  int                m_age;
  logic              m_last;
  logic              m_rsp_valid, m_rsp_id;
  logic [DATA_W-1:0] m_rsp_a, m_rsp_b;
  logic [ADDR_W-1:0] m_rfa, m_rfb;

  always #5 clk = ~clk;

  assign rf_a = mem[rf_addr_a];
  assign rf_b = mem[rf_addr_b];

  operand_fetch_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr_a(req0_addr_a), .req0_addr_b(req0_addr_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr_a(req1_addr_a), .req1_addr_b(req1_addr_b),
    .req1_ready(req1_ready),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_a(rf_a), .rf_b(rf_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = 1'b0; m_age = 0; m_last = 1'b1;
    m_rsp_valid = 1'b0; m_rsp_id = 1'b0;
    m_rsp_a = '0; m_rsp_b = '0; m_rfa = '0; m_rfb = '0;
  endfunction

  // Which requester should be granted this cycle: -1 for none.
  function automatic int model_winner();
    if (reset || m_pend) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Check all outputs against the model, advance the model with this
  // cycle's inputs, then move to just after the next rising edge.
  task automatic tick();
    int w;
    #1;
    w = model_winner();
    chk("req0_ready", req0_ready, w == 0);
    chk("req1_ready", req1_ready, w == 1);
    chk("busy",       busy,       m_pend);
    chk("rsp_valid",  rsp_valid,  m_rsp_valid);
    chk("rsp_id",     rsp_id,     m_rsp_id);
    chk("rsp_a",      rsp_a,      m_rsp_a);
    chk("rsp_b",      rsp_b,      m_rsp_b);
    chk("rf_addr_a",  rf_addr_a,  m_rfa);
    chk("rf_addr_b",  rf_addr_b,  m_rfb);
    if (reset) begin
      model_reset();
    end else if (w >= 0) begin
      m_pend   = 1'b1;
      m_age    = 1;
      m_last   = w[0];
      m_rsp_id = w[0];
      m_rfa    = (w == 1) ? req1_addr_a : req0_addr_a;
      m_rfb    = (w == 1) ? req1_addr_b : req0_addr_b;
    end else if (m_pend) begin
      if (m_age == 1) begin
        m_rsp_a     = mem[m_rfa];
        m_rsp_b     = mem[m_rfb];
        m_rsp_valid = 1'b1;
        m_age       = 2;
      end else if (rsp_ready) begin
        m_pend      = 1'b0;
        m_rsp_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h000A; mem[1] = 16'h0005; mem[4] = 16'h00FF; mem[10] = 16'h0040;

    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_addr_a = '0; req0_addr_b = '0;
    req1_valid = 1'b0; req1_addr_a = '0; req1_addr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    tick();

    // Single request from requester 0
    req0_valid = 1'b1; req0_addr_a = 4'd0; req0_addr_b = 4'd1;
    #1;
    chk("single_rdy0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    chk("single_vld", rsp_valid, 1'b1);
    chk("single_id",  rsp_id, 1'b0);
    chk("single_a",   rsp_a, 16'h000A);
    chk("single_b",   rsp_b, 16'h0005);
    tick();
    tick();

    // Contention right after reset
    reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_addr_a = 4'd4; req0_addr_b = 4'd10;
    req1_valid = 1'b1; req1_addr_a = 4'd1; req1_addr_b = 4'd0;
    #1;
    chk("cont_rdy0", req0_ready, 1'b1);
    chk("cont_rdy1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    chk("cont0_a",  rsp_a, 16'h00FF);
    chk("cont0_b",  rsp_b, 16'h0040);
    chk("cont0_id", rsp_id, 1'b0);
    tick();
    #1;
    chk("cont_rdy1_next", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick();
    #1;
    chk("cont1_a",  rsp_a, 16'h0005);
    chk("cont1_b",  rsp_b, 16'h000A);
    chk("cont1_id", rsp_id, 1'b1);
    tick();
    tick();

    // Fairness: both requesters valid continuously
    req0_valid = 1'b1; req1_valid = 1'b1;
    g = 0;
    for (int c = 0; c < 60 && g < 6; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("fair_id", req1_ready, g % 2);
        g++;
      end
      tick();
    end
    chk("fair_grants", g, 6);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    // Backpressure in HOLD
    reset = 1'b1; tick(); reset = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_addr_a = 4'd4; req0_addr_b = 4'd10;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr_a = 4'd1; req1_addr_b = 4'd0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_vld",  rsp_valid, 1'b1);
      chk("bp_a",    rsp_a, 16'h00FF);
      chk("bp_b",    rsp_b, 16'h0040);
      chk("bp_id",   rsp_id, 1'b0);
      chk("bp_rdy0", req0_ready, 1'b0);
      chk("bp_rdy1", req1_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_clear", rsp_valid, 1'b0);
    tick();
    req1_valid = 1'b0;
    repeat (3) tick();

    // Reset during the FETCH cycle
    req0_valid = 1'b1; req0_addr_a = 4'd4; req0_addr_b = 4'd10;
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rmf_vld",  rsp_valid, 1'b0);
    chk("rmf_busy", busy, 1'b0);
    chk("rmf_rfa",  rf_addr_a, 4'd0);
    chk("rmf_rfb",  rf_addr_b, 4'd0);
    chk("rmf_a",    rsp_a, 16'h0000);
    chk("rmf_id",   rsp_id, 1'b0);
    repeat (3) tick();

    // Address change after acceptance
    req1_valid = 1'b1; req1_addr_a = 4'd0; req1_addr_b = 4'd1;
    #1;
    chk("ach_rdy1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0; req1_addr_a = 4'd4;
    tick();
    #1;
    chk("ach_a",  rsp_a, 16'h000A);
    chk("ach_id", rsp_id, 1'b1);
    repeat (2) tick();

    // Random traffic, register file contents changing underneath
    for (int c = 0; c < 800; c++) begin
      reset       = ($urandom_range(0, 59) == 0);
      req0_valid  = $urandom_range(0, 1);
      req1_valid  = $urandom_range(0, 1);
      req0_addr_a = ADDR_W'($urandom);
      req0_addr_b = ADDR_W'($urandom);
      req1_addr_a = ADDR_W'($urandom);
      req1_addr_b = ADDR_W'($urandom);
      rsp_ready   = ($urandom_range(0, 9) < 6);
      mem[$urandom_range(0, 15)] = DATA_W'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_arbiter.md
OPERAND_FETCH_ARBITER -- requirements
Module: operand_fetch_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 16, operand width.
- ADDR_W, 4, register-file address width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- req0_valid, in, 1, requester 0 fetch request.
- req0_addr_a, in, ADDR_W, requester 0 operand-a address.
- req0_addr_b, in, ADDR_W, requester 0 operand-b address.
- req0_ready, out, 1, requester 0 request accepted this cycle.
- req1_valid, in, 1, requester 1 fetch request.
- req1_addr_a, in, ADDR_W, requester 1 operand-a address.
- req1_addr_b, in, ADDR_W, requester 1 operand-b address.
- req1_ready, out, 1, requester 1 request accepted this cycle.
- rf_addr_a, out, ADDR_W, address to data register file port a.
- rf_addr_b, out, ADDR_W, address to data register file port b.
- rf_a, in, DATA_W, combinational read data, port a.
- rf_b, in, DATA_W, combinational read data, port b.
- rsp_valid, out, 1, response holds fetched operands.
- rsp_id, out, 1, requester that owns the response.
- rsp_a, out, DATA_W, fetched operand a.
- rsp_b, out, DATA_W, fetched operand b.
- rsp_ready, in, 1, consumer accepts the response.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, FETCH and HOLD. Transitions:
- IDLE->FETCH on an accepted request.
- FETCH->HOLD unconditionally after one cycle.
- HOLD->IDLE on rsp_ready.
REQ-004 In IDLE, the block SHALL assert reqN_ready combinationally for exactly one requester whose reqN_valid is high.
- Both ready outputs SHALL be 0 in FETCH and HOLD.
- Both ready outputs SHALL be 0 in IDLE when neither valid is high.
REQ-005 Arbitration SHALL be round-robin.
- On simultaneous valid, the requester not recorded in last_grant wins.
- On a single valid, that requester wins regardless of last_grant.
- last_grant SHALL update to the winner on each acceptance.
REQ-006 On acceptance (valid && ready), the block SHALL register the winner's addr_a and addr_b into rf_addr_a and rf_addr_b, and register the winner's index into rsp_id.
REQ-007 rf_addr_a and rf_addr_b SHALL change only on acceptance or reset; they SHALL hold their value in all other cycles.
REQ-008 At the end of the FETCH cycle, the block SHALL capture rf_a and rf_b into rsp_a and rsp_b and set rsp_valid.
REQ-009 Latency SHALL be: acceptance in cycle N, then rsp_valid high in cycle N+2.
REQ-010 While rsp_valid && !rsp_ready, rsp_a, rsp_b and rsp_id SHALL hold stable.
REQ-011 rsp_valid SHALL clear in the cycle after the handshake (rsp_valid && rsp_ready).
- New requests are not accepted in that same handshake cycle.
- Maximum throughput is one fetch per 3 cycles.
REQ-012 rsp_ready asserted in IDLE or FETCH SHALL have no effect.
REQ-013 The block SHALL ignore requester valid and address changes made after acceptance.
- Requesters SHALL hold valid and addresses stable until their ready is seen.
REQ-014 Address values 0..15 SHALL all be passed through unmodified; the block does no range checking.

Reset
REQ-015 While reset is high at a rising clk edge, the block SHALL set:
- state = IDLE;
- rsp_valid = 0, rsp_id = 0, rsp_a = 0, rsp_b = 0;
- rf_addr_a = 0, rf_addr_b = 0;
- last_grant = 1 (requester 0 wins the first contention).
REQ-016 While reset is high, req0_ready and req1_ready SHALL be forced to 0.
REQ-017 Reset asserted in FETCH or HOLD SHALL discard the in-flight fetch with no response emitted; busy = 0 on the following cycle.

Verification
REQ-018 The bench SHALL cover these scenarios. Register contents: mem[0]=0x000A, mem[1]=0x0005, mem[4]=0x00FF, mem[10]=0x0040.
- Single request: req0 addresses (0,1), rsp_ready=1 -> req0_ready high in the accept cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_a=0x000A, rsp_b=0x0005.
- Contention after reset: req0 (4,10) and req1 (1,0) both valid -> req0 granted first (rsp 0x00FF/0x0040, id 0); req1 granted next (rsp 0x0005/0x000A, id 1).
- Fairness: both requesters valid continuously for 6 grants -> grant ids alternate 0,1,0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles in HOLD -> rsp_* stable, both readies 0, busy=1; rsp_ready=1 -> rsp_valid clears on the next cycle.
- Reset mid-fetch: reset asserted in the FETCH cycle -> no rsp_valid pulse; all outputs at their reset values on the next cycle.
- Address change after accept: req1_addr_a changes 0->4 one cycle after acceptance -> rsp_a still equals mem[0]=0x000A.
